writeback_collector: RTL and testbench
======================================

Name: writeback_collector

Overview:
- Completion end of the issue/dispatch path: accepts finished results from the functional units that issue dispatches to, and buffers one result per unit.
- Arbitrates the single register-file write port round-robin.
- Emits the scoreboard clear (write address + enable) that retires the pending bit set at issue.
- Sits between the execution units and the register file / scoreboard.

Parameters:
- NUM_UNITS, 3, number of functional units (unit index matches the 2-bit issue func_unit code; 0=ALU, 1=MEM, 2=SHIFT/MUL).
- DATA_W, 32, result width.
- ADDR_W, 5, register address width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- fu_wb_valid  in  NUM_UNITS  per-unit result valid.
- fu_wb_ready  out  NUM_UNITS  per-unit buffer can accept.
- fu_wb_data  in  NUM_UNITS*DATA_W  result, unit i at [i*DATA_W +: DATA_W].
- fu_wb_regdest  in  NUM_UNITS*ADDR_W  destination register.
- fu_wb_writereg  in  NUM_UNITS  instruction writes a register.
- fu_wb_writeov  in  NUM_UNITS  overflow suppresses the write.
- fu_wb_overflow  in  NUM_UNITS  unit detected overflow.
- wb_reg_addr  out  ADDR_W  register-file write address.
- wb_reg_data  out  DATA_W  register-file write data.
- wb_reg_write  out  1  register-file write enable.
- wb_sb_addr  out  ADDR_W  scoreboard clear address.
- wb_sb_clear  out  1  scoreboard clear enable.
- wb_sb_unit  out  2  unit that produced the retiring result.
- wb_ovf_exc  out  1  one-cycle overflow-exception pulse.
- wb_busy  out  1  any buffer holds a result.

Behaviour:
- Per-unit one-entry buffer {held, data, regdest, writereg, kill}.
  - kill = writeov & overflow, computed at capture.
- Handshake:
  - fu_wb_ready[i] = ~held[i] | grant[i].
  - Capture on valid[i] & ready[i] at the rising edge; held[i] is set.
  - valid is ignored while ready is low; the unit must hold its data.
- Arbitration:
  - grant is combinational from held and rr_ptr only; no path from valid.
  - grant goes to the first held unit at or after rr_ptr, wrapping modulo NUM_UNITS.
  - At most one grant per cycle.
  - On a grant, rr_ptr <= (granted+1) mod NUM_UNITS.
  - rr_ptr is unchanged when nothing is granted.
- Granted buffer clears at the same edge. Simultaneous grant and new capture on the same unit: the new entry wins and held stays 1.
- Outputs are registered. Latency from the capture edge to wb_reg_write high is 2 edges.
  - Edge 1: capture.
  - Edge 2: granted entry loaded into the output registers.
  - All pulse outputs are high for exactly one cycle.
- Output rules for a granted entry:
  - wb_reg_write = writereg & ~kill & (regdest != 0).
  - wb_sb_clear = writereg, including when killed or regdest==0.
  - wb_ovf_exc = kill.
  - wb_reg_addr / wb_sb_addr = regdest; wb_reg_data = data; wb_sb_unit = index.
- No grant in a cycle: all pulse outputs 0 the next cycle; addr/data hold their last value.
- Throughput: one retirement per cycle aggregate; any single unit sustains one result per cycle when it is alone.
- Reset (synchronous, also mid-operation): all held<=0, rr_ptr<=0, all outputs 0, so fu_wb_ready = all ones in the following cycle. In-flight results are discarded.
- wb_busy = |held (combinational from registers).

Decomposition:
- Shared package wb_pkg holds:
  - NUM_UNITS, DATA_W, ADDR_W defaults;
  - unit codes FU_ALU=2'd0, FU_MEM=2'd1, FU_SHIFT=2'd2;
  - entry struct/typedef {data, regdest, writereg, kill}.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], ptr;
  - outputs: one-hot grant, grant index, any_grant;
  - purely combinational.
- Buffers, pointer and output registers live in writeback_collector.

Test Plan:
- Single result: unit 0 valid, regdest=5, data=0xDEADBEEF, writereg=1 → 2 edges later wb_reg_write=1, addr=5, data=0xDEADBEEF, wb_sb_clear=1, wb_sb_unit=0; one cycle only.
- Three simultaneous results with rr_ptr=0, regdest 1/2/3 → writes in order 1,2,3 on consecutive cycles. A second burst after that grants starting at unit 0 again, since rr_ptr=0 after unit 2 wraps.
- Back-to-back on unit 1, valid every cycle, 4 results → fu_wb_ready[1] stays 1 and writes appear on 4 consecutive cycles.
- Overflow: writeov=1, overflow=1, regdest=7 → wb_reg_write=0, wb_sb_clear=1 addr=7, wb_ovf_exc=1. With writeov=0 and overflow=1 → normal write.
- r0 / no-write: regdest=0 writereg=1 → wb_reg_write=0, wb_sb_clear=1. writereg=0 → both 0, and the buffer is still freed.
- Reset mid-operation: all three buffers held, reset asserted one cycle → no writes afterward, wb_busy=0, fu_wb_ready=3'b111, and the next grant comes from unit 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback collector slice.
// Holds default sizing, the functional-unit codes that match the issue stage's
// func_unit field, and the per-unit result buffer entry layout.
package wb_pkg;

  localparam int NUM_UNITS = 3;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;

  // Unit index doubles as the 2-bit func_unit code used at issue.
  typedef enum logic [1:0] {
    FU_ALU   = 2'd0,
    FU_MEM   = 2'd1,
    FU_SHIFT = 2'd2
  } fu_unit_e;

  // One buffered result. kill is resolved at capture so the retire path
  // only needs a single bit to suppress the register write.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] regdest;
    logic              writereg;
    logic              kill;
  } wb_entry_t;

endpackage

// File: rtl/writeback_collector_if.sv
// Bus bundle between the functional units and the writeback collector, plus
// the register-file / scoreboard retire outputs.
//   fu_wb_*   : per-unit result handshake (valid/ready) and payload
//   wb_reg_*  : register-file write port
//   wb_sb_*   : scoreboard clear and producing unit
//   wb_ovf_exc: overflow exception pulse, wb_busy: any buffer occupied
// master = execution side driving results, slave = the collector.
interface writeback_collector_if
  import wb_pkg::*;
#(
  parameter int NUM_UNITS = wb_pkg::NUM_UNITS,
  parameter int DATA_W    = wb_pkg::DATA_W,
  parameter int ADDR_W    = wb_pkg::ADDR_W
);

  logic [NUM_UNITS-1:0]        fu_wb_valid;
  logic [NUM_UNITS-1:0]        fu_wb_ready;
  logic [NUM_UNITS*DATA_W-1:0] fu_wb_data;
  logic [NUM_UNITS*ADDR_W-1:0] fu_wb_regdest;
  logic [NUM_UNITS-1:0]        fu_wb_writereg;
  logic [NUM_UNITS-1:0]        fu_wb_writeov;
  logic [NUM_UNITS-1:0]        fu_wb_overflow;

  logic [ADDR_W-1:0]           wb_reg_addr;
  logic [DATA_W-1:0]           wb_reg_data;
  logic                        wb_reg_write;
  logic [ADDR_W-1:0]           wb_sb_addr;
  logic                        wb_sb_clear;
  logic [1:0]                  wb_sb_unit;
  logic                        wb_ovf_exc;
  logic                        wb_busy;

  modport master (
    output fu_wb_valid, fu_wb_data, fu_wb_regdest, fu_wb_writereg,
           fu_wb_writeov, fu_wb_overflow,
    input  fu_wb_ready, wb_reg_addr, wb_reg_data, wb_reg_write,
           wb_sb_addr, wb_sb_clear, wb_sb_unit, wb_ovf_exc, wb_busy
  );

  modport slave (
    input  fu_wb_valid, fu_wb_data, fu_wb_regdest, fu_wb_writereg,
           fu_wb_writeov, fu_wb_overflow,
    output fu_wb_ready, wb_reg_addr, wb_reg_data, wb_reg_write,
           wb_sb_addr, wb_sb_clear, wb_sb_unit, wb_ovf_exc, wb_busy
  );

endinterface

// File: rtl/writeback_collector_arbiter.sv
// Purely combinational round-robin arbiter.
//   req_i       : request per requester
//   ptr_i       : highest-priority requester this cycle
//   grant_o     : one-hot grant
//   grant_idx_o : index of the granted requester
//   any_grant_o : some requester was granted
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_grant_o
);

  // Scan from ptr_i upward with wraparound; the first requester found wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!any_grant_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
        any_grant_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_collector.sv
// Writeback collector: one result buffer per functional unit, round-robin
// arbitration of the single register-file write port, and the scoreboard
// clear that retires the pending bit set at issue.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : unit result handshakes in, register-file/scoreboard out
// Results appear on the write port two edges after capture (capture, then
// load into the output registers).
module writeback_collector
  import wb_pkg::*;
#(
  parameter int NUM_UNITS = wb_pkg::NUM_UNITS,
  parameter int DATA_W    = wb_pkg::DATA_W,
  parameter int ADDR_W    = wb_pkg::ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  writeback_collector_if.slave  bus
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0] held_q, held_d;
  logic [NUM_UNITS-1:0] ready, capture, grant;
  wb_entry_t            entry_q   [NUM_UNITS];
  wb_entry_t            new_entry [NUM_UNITS];
  wb_entry_t            sel;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, grant_idx;
  logic                 any_grant;

  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [1:0]           unit_q, unit_d;
  logic                 reg_write_q, reg_write_d;
  logic                 sb_clear_q, sb_clear_d;
  logic                 ovf_q, ovf_d;

  // Grant depends only on buffer occupancy and the pointer, never on valid.
  rr_arbiter #(.N(NUM_UNITS), .IDX_W(IDX_W)) u_arb (
    .req_i       (held_q),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  // A buffer being drained this cycle can accept a new result at the same edge.
  assign ready           = ~held_q | grant;
  assign capture         = bus.fu_wb_valid & ready;
  assign bus.fu_wb_ready = ready;
  assign bus.wb_busy     = |held_q;

  // Unpack the flat unit buses and resolve overflow suppression at capture.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      new_entry[i].data     = bus.fu_wb_data[i*DATA_W +: DATA_W];
      new_entry[i].regdest  = bus.fu_wb_regdest[i*ADDR_W +: ADDR_W];
      new_entry[i].writereg = bus.fu_wb_writereg[i];
      new_entry[i].kill     = bus.fu_wb_writeov[i] & bus.fu_wb_overflow[i];
    end
  end

  // A new capture wins over the drain of the same buffer, keeping it held.
  always_comb begin
    held_d = (held_q & ~grant) | capture;
  end

  // Pointer moves one past the winner; it stays put on idle cycles.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Retire decode. Killed or r0 results still clear the scoreboard; the
  // address/data/unit registers keep their value when nothing retires.
  always_comb begin
    sel         = entry_q[grant_idx];
    addr_d      = addr_q;
    data_d      = data_q;
    unit_d      = unit_q;
    reg_write_d = 1'b0;
    sb_clear_d  = 1'b0;
    ovf_d       = 1'b0;
    if (any_grant) begin
      addr_d      = sel.regdest;
      data_d      = sel.data;
      unit_d      = 2'(grant_idx);
      reg_write_d = sel.writereg & ~sel.kill & (sel.regdest != '0);
      sb_clear_d  = sel.writereg;
      ovf_d       = sel.kill;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      held_q      <= '0;
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      unit_q      <= '0;
      reg_write_q <= 1'b0;
      sb_clear_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      held_q      <= held_d;
      rr_ptr_q    <= rr_ptr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      unit_q      <= unit_d;
      reg_write_q <= reg_write_d;
      sb_clear_q  <= sb_clear_d;
      ovf_q       <= ovf_d;
    end
  end

  // Payload storage needs no reset; held_q qualifies it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (capture[i]) begin
        entry_q[i] <= new_entry[i];
      end
    end
  end

  assign bus.wb_reg_addr  = addr_q;
  assign bus.wb_reg_data  = data_q;
  assign bus.wb_reg_write = reg_write_q;
  assign bus.wb_sb_addr   = addr_q;
  assign bus.wb_sb_clear  = sb_clear_q;
  assign bus.wb_sb_unit   = unit_q;
  assign bus.wb_ovf_exc   = ovf_q;

endmodule

// File: tb/tb_writeback_collector.sv
// Self-checking bench for writeback_collector. Stimulus pushes the expected
// retirement (including the edge it must appear on) into a queue; a monitor
// on the falling edge pops and compares whenever a retire pulse is visible.
module tb_writeback_collector;
  import wb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   edgeCount = 0;
  int   checks    = 0;
  int   failures  = 0;

  typedef struct {
    logic        regWrite;
    logic        sbClear;
    logic        ovfExc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  unit;
    int          edgeN;
  } expect_t;

  expect_t expQ[$];

  writeback_collector_if bus ();

  writeback_collector dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edgeCount++;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic setUnit(input int u, input logic [31:0] data, input logic [4:0] rd,
                         input logic wr, input logic wov, input logic ovf);
    bus.fu_wb_data[u*32 +: 32]  = data;
    bus.fu_wb_regdest[u*5 +: 5] = rd;
    bus.fu_wb_writereg[u]       = wr;
    bus.fu_wb_writeov[u]        = wov;
    bus.fu_wb_overflow[u]       = ovf;
  endtask

  task automatic pushExpect(input logic rw, input logic clr, input logic ovf,
                            input logic [4:0] addr, input logic [31:0] data,
                            input logic [1:0] unit, input int edgeN);
    expect_t e;
    e.regWrite = rw;
    e.sbClear  = clr;
    e.ovfExc   = ovf;
    e.addr     = addr;
    e.data     = data;
    e.unit     = unit;
    e.edgeN    = edgeN;
    expQ.push_back(e);
  endtask

  // Present results on the masked units for exactly one edge.
  task automatic applyStimulus(input logic [2:0] mask);
    bus.fu_wb_valid = mask;
    tick(1);
    bus.fu_wb_valid = '0;
  endtask

  // Monitor: any visible retire pulse must match the head of the queue.
  always @(negedge clock) begin
    if (reset === 1'b0 && (bus.wb_reg_write === 1'b1 || bus.wb_sb_clear === 1'b1 ||
                           bus.wb_ovf_exc === 1'b1)) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse actual write=%b clear=%b ovf=%b addr=%0d required=none",
                 bus.wb_reg_write, bus.wb_sb_clear, bus.wb_ovf_exc, bus.wb_reg_addr);
      end else begin
        expect_t e;
        e = expQ.pop_front();
        checkOutput("wb_edge",      64'(edgeCount),        64'(e.edgeN));
        checkOutput("wb_reg_write", 64'(bus.wb_reg_write), 64'(e.regWrite));
        checkOutput("wb_sb_clear",  64'(bus.wb_sb_clear),  64'(e.sbClear));
        checkOutput("wb_ovf_exc",   64'(bus.wb_ovf_exc),   64'(e.ovfExc));
        checkOutput("wb_reg_addr",  64'(bus.wb_reg_addr),  64'(e.addr));
        checkOutput("wb_sb_addr",   64'(bus.wb_sb_addr),   64'(e.addr));
        checkOutput("wb_reg_data",  64'(bus.wb_reg_data),  64'(e.data));
        checkOutput("wb_sb_unit",   64'(bus.wb_sb_unit),   64'(e.unit));
      end
    end
  end

  initial begin
    int d;
    reset              = 1'b1;
    bus.fu_wb_valid    = '0;
    bus.fu_wb_data     = '0;
    bus.fu_wb_regdest  = '0;
    bus.fu_wb_writereg = '0;
    bus.fu_wb_writeov  = '0;
    bus.fu_wb_overflow = '0;
    tick(2);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset_ready",     64'(bus.fu_wb_ready),  64'h7);
    checkOutput("reset_busy",      64'(bus.wb_busy),      64'h0);
    checkOutput("reset_reg_write", 64'(bus.wb_reg_write), 64'h0);
    checkOutput("reset_sb_clear",  64'(bus.wb_sb_clear),  64'h0);
    checkOutput("reset_ovf",       64'(bus.wb_ovf_exc),   64'h0);
    checkOutput("reset_addr",      64'(bus.wb_reg_addr),  64'h0);
    checkOutput("reset_data",      64'(bus.wb_reg_data),  64'h0);

    $display("[TB] single result");
    setUnit(0, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 1'b0);
    pushExpect(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 2'd0, edgeCount + 2);
    applyStimulus(3'b001);
    tick(3);

    // Return the pointer to unit 0 before the burst.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;

    $display("[TB] three simultaneous results, two bursts");
    setUnit(0, 32'h11111111, 5'd1, 1'b1, 1'b0, 1'b0);
    setUnit(1, 32'h22222222, 5'd2, 1'b1, 1'b0, 1'b0);
    setUnit(2, 32'h33333333, 5'd3, 1'b1, 1'b0, 1'b0);
    d = edgeCount;
    pushExpect(1'b1, 1'b1, 1'b0, 5'd1, 32'h11111111, 2'd0, d + 2);
    pushExpect(1'b1, 1'b1, 1'b0, 5'd2, 32'h22222222, 2'd1, d + 3);
    pushExpect(1'b1, 1'b1, 1'b0, 5'd3, 32'h33333333, 2'd2, d + 4);
    applyStimulus(3'b111);
    tick(3);
    setUnit(0, 32'hA0A0A0A0, 5'd1, 1'b1, 1'b0, 1'b0);
    setUnit(1, 32'hA1A1A1A1, 5'd2, 1'b1, 1'b0, 1'b0);
    setUnit(2, 32'hA2A2A2A2, 5'd3, 1'b1, 1'b0, 1'b0);
    d = edgeCount;
    pushExpect(1'b1, 1'b1, 1'b0, 5'd1, 32'hA0A0A0A0, 2'd0, d + 2);
    pushExpect(1'b1, 1'b1, 1'b0, 5'd2, 32'hA1A1A1A1, 2'd1, d + 3);
    pushExpect(1'b1, 1'b1, 1'b0, 5'd3, 32'hA2A2A2A2, 2'd2, d + 4);
    applyStimulus(3'b111);
    tick(4);

    $display("[TB] back-to-back on unit 1");
    d = edgeCount;
    bus.fu_wb_valid = 3'b010;
    for (int k = 0; k < 4; k++) begin
      setUnit(1, 32'hB0000000 + 32'(k), 5'(20 + k), 1'b1, 1'b0, 1'b0);
      pushExpect(1'b1, 1'b1, 1'b0, 5'(20 + k), 32'hB0000000 + 32'(k), 2'd1, d + 2 + k);
      checkOutput("b2b_ready1", 64'(bus.fu_wb_ready[1]), 64'h1);
      tick(1);
    end
    bus.fu_wb_valid = '0;
    tick(6);

    $display("[TB] overflow handling");
    setUnit(2, 32'hC0FFEE00, 5'd7, 1'b1, 1'b1, 1'b1);
    pushExpect(1'b0, 1'b1, 1'b1, 5'd7, 32'hC0FFEE00, 2'd2, edgeCount + 2);
    applyStimulus(3'b100);
    tick(3);
    setUnit(0, 32'h12345678, 5'd9, 1'b1, 1'b0, 1'b1);
    pushExpect(1'b1, 1'b1, 1'b0, 5'd9, 32'h12345678, 2'd0, edgeCount + 2);
    applyStimulus(3'b001);
    tick(3);

    $display("[TB] r0 and no-write results");
    setUnit(1, 32'h55AA55AA, 5'd0, 1'b1, 1'b0, 1'b0);
    pushExpect(1'b0, 1'b1, 1'b0, 5'd0, 32'h55AA55AA, 2'd1, edgeCount + 2);
    applyStimulus(3'b010);
    tick(3);
    setUnit(0, 32'h00000066, 5'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b001);
    checkOutput("nowrite_busy_held", 64'(bus.wb_busy), 64'h1);
    tick(1);
    checkOutput("nowrite_busy_freed", 64'(bus.wb_busy),     64'h0);
    checkOutput("nowrite_ready",      64'(bus.fu_wb_ready), 64'h7);
    tick(3);

    $display("[TB] reset mid-operation");
    setUnit(0, 32'hE0E0E0E0, 5'd13, 1'b1, 1'b0, 1'b0);
    setUnit(1, 32'hE1E1E1E1, 5'd14, 1'b1, 1'b0, 1'b0);
    setUnit(2, 32'hE2E2E2E2, 5'd15, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'b111);
    checkOutput("midrst_busy_before", 64'(bus.wb_busy), 64'h1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("midrst_busy",      64'(bus.wb_busy),      64'h0);
    checkOutput("midrst_ready",     64'(bus.fu_wb_ready),  64'h7);
    checkOutput("midrst_reg_write", 64'(bus.wb_reg_write), 64'h0);
    checkOutput("midrst_sb_clear",  64'(bus.wb_sb_clear),  64'h0);
    tick(4);
    setUnit(0, 32'hF0F0F0F0, 5'd10, 1'b1, 1'b0, 1'b0);
    setUnit(1, 32'hF1F1F1F1, 5'd11, 1'b1, 1'b0, 1'b0);
    setUnit(2, 32'hF2F2F2F2, 5'd12, 1'b1, 1'b0, 1'b0);
    d = edgeCount;
    pushExpect(1'b1, 1'b1, 1'b0, 5'd10, 32'hF0F0F0F0, 2'd0, d + 2);
    pushExpect(1'b1, 1'b1, 1'b0, 5'd11, 32'hF1F1F1F1, 2'd1, d + 3);
    pushExpect(1'b1, 1'b1, 1'b0, 5'd12, 32'hF2F2F2F2, 2'd2, d + 4);
    applyStimulus(3'b111);
    tick(4);

    // Bounded drain: anything left in the queue never retired.
    for (int w = 0; w < 50 && expQ.size() != 0; w++) tick(1);
    checkOutput("drain_pending", 64'(expQ.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
